selector_scan: RTL and testbench
================================

// Module: selector_scan
// PURPOSE
//   Parametrised CH-channel, W-bit selector with registered output and two modes:
//   manual select, where the channel comes from iSel, and auto-scan, where an internal
//   dwell counter steps through every channel in turn.
//   Used wherever one data path or display is shared between several sources, such as
//   time-multiplexed display digits or the lab I/O front end.
// PARAMETERS
//   CH     4   number of input channels; 2..16, need not be a power of two
//   W      4   bits per channel
//   DWELL  4   clock cycles spent on each channel in scan mode; >=1
// PORTS
//   iClk    in   1             rising-edge clock
//   iRst_n  in   1             asynchronous active-low reset
//   iData   in   CH*W          flattened channels; channel k = iData[k*W +: W]
//   iSel    in   SW            manual channel index; SW = max(1,$clog2(CH))
//   iMode   in   1             0 = manual, 1 = auto-scan
//   iHold   in   1             1 = freeze scan position; ignored in manual mode
//   oZ      out  W             registered selected data
//   oCh     out  SW            channel index currently driving oZ
//   oNew    out  1             one-cycle pulse, high in the cycle after oCh changes value
// BEHAVIOUR
//   Reset (async, iRst_n=0):
//   - oZ=0, oCh=0, oNew=0, dwell counter=0, state=MANUAL. Takes effect immediately,
//     including mid-scan.
//   Output consistency:
//   - Each edge loads nxt_ch into oCh and iData[nxt_ch] into oZ together, so oZ is
//     always channel oCh's data from the previous cycle (1-cycle latency).
//   - oNew <= (nxt_ch != oCh).
//   States: MANUAL, SCAN, HOLD. iMode has priority over iHold.
//   - MANUAL: nxt_ch = iSel if iSel < CH, otherwise nxt_ch = oCh (out-of-range select
//     ignored). Counter held at 0. iMode=1 -> SCAN.
//   - SCAN: counter increments each cycle. When counter == DWELL-1: counter <= 0 and
//     nxt_ch = (oCh == CH-1) ? 0 : oCh+1. Otherwise nxt_ch = oCh.
//     iMode=0 -> MANUAL. iHold=1 -> HOLD.
//   - HOLD: counter and oCh frozen; oZ keeps resampling iData[oCh] every cycle.
//     iMode=0 -> MANUAL. iHold=0 -> SCAN, counter resumes from its frozen value.
//   Mode entry and exit:
//   - On entry to SCAN from MANUAL, scanning starts at the current oCh with counter=0.
//     The first advance comes DWELL cycles later.
//   - On the exit cycle to MANUAL, nxt_ch already follows the MANUAL rule (iSel).
//   Transition timing:
//   - State transitions take effect on the edge where the input is sampled.
//   - The nxt_ch computed in that same cycle uses the rules of the current (old) state.
//   Boundaries:
//   - DWELL=1 advances every cycle.
//   - CH not a power of two: wrap is at CH-1, never at 2^SW-1.
//   - iHold asserted on the same edge as an advance: the advance happens, then the
//     block freezes.
//   - Data changes while channel is unchanged: oZ follows one cycle later, oNew stays 0.
// TESTING (CH=4, W=4, DWELL=4, C0=0001 C1=0010 C2=0100 C3=1000)
//   1 Reset, then manual iSel=0,1,2,3, each held 2 cycles -> oZ=0001,0010,0100,1000;
//     each value appears 1 cycle after iSel changes; oNew pulses once per change.
//   2 iMode=1 from oCh=0 -> oCh steps 0,1,2,3,0 every 4 cycles; oZ matches oCh;
//     oNew pulses at each step, including the 3->0 wrap.
//   3 Scan at oCh=1 with counter=2; iHold=1 for 10 cycles, then 0 -> oCh stays 1
//     during the hold; the advance to 2 comes 2 cycles after release.
//     Change C1 to 1111 during the hold -> oZ=1111 one cycle later.
//   4 Scan at oCh=2; iMode=0 with iSel=0 -> next edge oCh=0, oZ=0001, oNew=1, state
//     MANUAL. Then iHold=1 in manual -> no effect.
//   5 CH=3 build: scan wraps 0,1,2,0. Manual iSel=3 -> oCh and oZ unchanged, oNew=0.
//   6 iRst_n low mid-scan, asynchronously between edges -> oZ=0, oCh=0, oNew=0
//     immediately. After release with iMode=1, the first advance comes 4 cycles later.

Source files
------------

// File: rtl/selector_scan.sv
// CH-channel, W-bit selector with a registered output. Channel comes either from iSel
// (manual) or from an internal dwell counter that walks every channel in turn (scan).
module selector_scan #(
    parameter int unsigned CH    = 4,
    parameter int unsigned W     = 4,
    parameter int unsigned DWELL = 4,
    localparam int unsigned SW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            iClk,
    input  logic            iRst_n,
    input  logic [CH*W-1:0] iData,
    input  logic [SW-1:0]   iSel,
    input  logic            iMode,
    input  logic            iHold,
    output logic [W-1:0]    oZ,
    output logic [SW-1:0]   oCh,
    output logic            oNew
);

    localparam int unsigned CW      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SW-1:0] LastCh  = SW'(CH - 1);
    localparam logic [CW-1:0] LastCnt = CW'(DWELL - 1);

    localparam logic [1:0] StManual = 2'd0;
    localparam logic [1:0] StScan   = 2'd1;
    localparam logic [1:0] StHold   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] ch_q, nxt_ch;
    logic [W-1:0]  z_q, z_d;
    logic          new_q, new_d;
    logic [SW-1:0] manual_ch;

    // Out-of-range selects (possible when CH is not a power of two) keep the current channel.
    always_comb begin
        manual_ch = ch_q;
        if (32'(iSel) < CH) begin
            manual_ch = iSel;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nxt_ch  = ch_q;
        case (state_q)
            StScan: begin
                if (cnt_q == LastCnt) begin
                    cnt_d  = '0;
                    nxt_ch = (ch_q == LastCh) ? '0 : ch_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!iMode) begin
                    state_d = StManual;
                    cnt_d   = '0;
                    nxt_ch  = manual_ch;
                end else if (iHold) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!iMode) begin
                    state_d = StManual;
                    cnt_d   = '0;
                    nxt_ch  = manual_ch;
                end else if (!iHold) begin
                    state_d = StScan;
                end
            end
            default: begin
                state_d = iMode ? StScan : StManual;
                cnt_d   = '0;
                nxt_ch  = manual_ch;
            end
        endcase
    end

    always_comb begin
        z_d = '0;
        for (int k = 0; k < int'(CH); k++) begin
            if (nxt_ch == SW'(k)) begin
                z_d = iData[k*W +: W];
            end
        end
        new_d = (nxt_ch != ch_q);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= StManual;
            cnt_q   <= '0;
            ch_q    <= '0;
            z_q     <= '0;
            new_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= nxt_ch;
            z_q     <= z_d;
            new_q   <= new_d;
        end
    end

    assign oZ   = z_q;
    assign oCh  = ch_q;
    assign oNew = new_q;

endmodule

// File: tb/tb_selector_scan.sv
// Self-checking bench for selector_scan: a 4-channel DUT checked against a scoreboard
// model, plus a 3-channel DWELL=1 DUT checked with directed expectations.
module tb_selector_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_a;
    logic [1:0]  sel_a;
    logic        mode_a, hold_a;
    logic [3:0]  z_a;
    logic [1:0]  ch_a;
    logic        new_a;

    logic [11:0] data_b;
    logic [1:0]  sel_b;
    logic        mode_b, hold_b;
    logic [3:0]  z_b;
    logic [1:0]  ch_b;
    logic        new_b;

    logic [3:0] dat[4];

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [3:0] z;
        logic [1:0] ch;
        logic       nw;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state for DUT A: 0 manual, 1 scan, 2 hold
    int m_st, m_ch, m_cnt;

    selector_scan #(.CH(4), .W(4), .DWELL(4)) u_dut_a (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iData  (data_a),
        .iSel   (sel_a),
        .iMode  (mode_a),
        .iHold  (hold_a),
        .oZ     (z_a),
        .oCh    (ch_a),
        .oNew   (new_a)
    );

    selector_scan #(.CH(3), .W(4), .DWELL(1)) u_dut_b (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iData  (data_b),
        .iSel   (sel_b),
        .iMode  (mode_b),
        .iHold  (hold_b),
        .oZ     (z_b),
        .oCh    (ch_b),
        .oNew   (new_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb data_a = {dat[3], dat[2], dat[1], dat[0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Predict DUT A's next outputs from the current inputs, clock, then compare.
    task automatic step(input string tag);
        int   nxt, ncnt, nst, msel;
        exp_t e, got;
        nxt  = m_ch;
        ncnt = m_cnt;
        nst  = m_st;
        msel = (int'(sel_a) < 4) ? int'(sel_a) : m_ch;
        if (m_st == 0) begin
            nxt  = msel;
            ncnt = 0;
            if (mode_a) nst = 1;
        end else begin
            if (m_st == 1) begin
                if (m_cnt == 3) begin
                    ncnt = 0;
                    nxt  = (m_ch + 1) % 4;
                end else begin
                    ncnt = m_cnt + 1;
                end
            end
            if (!mode_a) begin
                nst  = 0;
                ncnt = 0;
                nxt  = msel;
            end else begin
                nst = hold_a ? 2 : 1;
            end
        end
        e.z  = dat[nxt];
        e.ch = 2'(nxt);
        e.nw = (nxt != m_ch);
        exp_q.push_back(e);
        m_ch  = nxt;
        m_cnt = ncnt;
        m_st  = nst;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            got = '{z: z_a, ch: ch_a, nw: new_a};
            check({tag, "_z"}, 32'(got.z), 32'(e.z));
            check({tag, "_ch"}, 32'(got.ch), 32'(e.ch));
            check({tag, "_new"}, 32'(got.nw), 32'(e.nw));
        end
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_ch  = 0;
        m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic step_b(input string tag, input int ech, input logic enew);
        logic [3:0] ez;
        logic [11:0] d;
        @(posedge clk);
        #1;
        d  = data_b;
        ez = d[ech*4 +: 4];
        check({tag, "_ch"}, 32'(ch_b), 32'(ech));
        check({tag, "_z"}, 32'(z_b), 32'(ez));
        check({tag, "_new"}, 32'(new_b), 32'(enew));
    endtask

    initial begin
        int k;
        dat[0] = 4'b0001; dat[1] = 4'b0010; dat[2] = 4'b0100; dat[3] = 4'b1000;
        sel_a = 2'd0; mode_a = 1'b0; hold_a = 1'b0;
        data_b = {4'b0100, 4'b0010, 4'b0001};
        sel_b = 2'd0; mode_b = 1'b0; hold_b = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #22;
        check("rst_z", 32'(z_a), 0);
        check("rst_ch", 32'(ch_a), 0);
        check("rst_new", 32'(new_a), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Manual selection, each select held two cycles
        for (int s = 0; s < 4; s++) begin
            sel_a = 2'(s);
            step("man_a");
            step("man_b");
        end

        // Scan from channel 0 through the 3->0 wrap
        sel_a = 2'd0;
        step("to0");
        mode_a = 1'b1;
        for (int i = 0; i < 18; i++) step("scan");

        // Reach ch=1, cnt=2, then hold with a data change mid-hold
        k = 0;
        while (!(m_st == 1 && m_ch == 1 && m_cnt == 2) && k < 40) begin
            step("seek1");
            k++;
        end
        check("seek1_bound", 32'(k < 40), 1);
        hold_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) dat[1] = 4'b1111;
            step("hold");
        end
        check("hold_ch", 32'(ch_a), 1);
        check("hold_z", 32'(z_a), 32'(4'b1111));
        hold_a = 1'b0;
        step("rel1");
        check("rel1_ch", 32'(ch_a), 1);
        step("rel2");
        check("rel2_ch", 32'(ch_a), 2);
        dat[1] = 4'b0010;

        // Leave scan at ch=2 back to manual select 0
        k = 0;
        while (m_ch != 2 && k < 40) begin
            step("seek2");
            k++;
        end
        check("seek2_bound", 32'(k < 40), 1);
        mode_a = 1'b0;
        sel_a  = 2'd0;
        step("exit");
        check("exit_ch", 32'(ch_a), 0);
        check("exit_z", 32'(z_a), 32'(4'b0001));
        check("exit_new", 32'(new_a), 1);
        hold_a = 1'b1;
        for (int i = 0; i < 4; i++) step("manhold");
        check("manhold_ch", 32'(ch_a), 0);
        hold_a = 1'b0;

        // Asynchronous reset in the middle of a scan
        mode_a = 1'b1;
        for (int i = 0; i < 6; i++) step("prerst");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_z", 32'(z_a), 0);
        check("arst_ch", 32'(ch_a), 0);
        check("arst_new", 32'(new_a), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step("post");
        check("post_ch", 32'(ch_a), 1);

        // CH=3, DWELL=1: wrap at 2, out-of-range select ignored
        mode_b = 1'b0;
        sel_b  = 2'd0;
        step_b("b_man0", 0, 1'b0);
        mode_b = 1'b1;
        step_b("b_s0", 0, 1'b0);
        step_b("b_s1", 1, 1'b1);
        step_b("b_s2", 2, 1'b1);
        step_b("b_wrap", 0, 1'b1);
        step_b("b_s4", 1, 1'b1);
        mode_b = 1'b0;
        sel_b  = 2'd3;
        step_b("b_oor0", 1, 1'b0);
        step_b("b_oor1", 1, 1'b0);
        sel_b = 2'd2;
        step_b("b_sel2", 2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
